instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 84 ++++++++
 tb/tb_instr_fetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: prefetching instruction fetch unit; `define IFETCH_HALT_DETECT_EN to stop fetching on the HALT word 32'hFFFFFFFF
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] iaddr_o,
  output logic        ird_o,
  input  logic        accept_i,
  input  logic [31:0] irdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        halted_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
  logic [31:0] pc, req_pc;
  logic inflight;
  logic [1:0] state;
  logic [31:0] mem_inst [FIFO_DEPTH];
  logic [31:0] mem_pc [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, occ;
  logic halt_word, push, pop;
`ifdef IFETCH_HALT_DETECT_EN
  assign halt_word = inflight && irdata_i == 32'hFFFF_FFFF;
  assign halted_o = !reset_i && state == HALTED;
`else
  assign halt_word = 1'b0;
  assign halted_o = 1'b0;
`endif
  assign push = !reset_i && inflight && !redirect_i && !halt_word;
  assign inst_valid_o = !reset_i && count != '0;
  assign pop = inst_valid_o && inst_ready_i;
  // occupancy the FIFO will have once the outstanding response lands
  assign occ = count + {{AW{1'b0}}, inflight} - {{AW{1'b0}}, pop};
  assign ird_o = !reset_i && state == RUN && !redirect_i && !halt_word && occ < DEPTH_C;
  assign iaddr_o = pc;
  assign inst_o = mem_inst[rd_ptr];
  assign inst_pc_o = mem_pc[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      inflight <= 1'b0;
      state <= RUN;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_i) begin
      pc <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
      state <= RUN;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= ird_o && accept_i;
      if (ird_o && accept_i) begin
        pc <= pc + 32'd4;
        req_pc <= pc;
      end
      if (push) begin
        mem_inst[wr_ptr] <= irdata_i;
        mem_pc[wr_ptr] <= req_pc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
`ifdef IFETCH_HALT_DETECT_EN
      if (halt_word && state == RUN) state <= DRAIN;
      else if (state == DRAIN && count == '0) state <= HALTED;
`endif
    end
  end
  always_ff @(posedge clk_i)
    if (push && !pop) assert (count < DEPTH_C) else $error("instr_fetch_ctrl fifo overflow");
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed stimulus with a program-order scoreboard and literal spot checks
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int FIFO_DEPTH = 2;
  logic clk_i = 1'b0, reset_i = 1'b1, ird_o, accept_i = 1'b1, redirect_i = 1'b0;
  logic inst_valid_o, inst_ready_i = 1'b1, halted_o;
  logic [31:0] iaddr_o, irdata_i = 32'h0, redirect_pc_i = 32'h0, inst_o, inst_pc_o;
  logic [31:0] mem_next = 32'h0, exp_f = 32'h0, exp_d = 32'h0, d4_val = 32'h0;
  logic hp = 1'b0, seen_d8 = 1'b0, seen_halt = 1'b0;
  int errors = 0, checks = 0, n = 0;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .iaddr_o(iaddr_o), .ird_o(ird_o), .accept_i(accept_i),
    .irdata_i(irdata_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .halted_o(halted_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'hD4) ? 32'hFFFF_FFFF : (32'h1000_0000 ^ a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic look();
    #2;
  endtask

  // instruction memory: one-cycle response to every accepted request
  always @(negedge clk_i) mem_next = (ird_o && accept_i) ? rom(iaddr_o) : 32'h0BAD_0BAD;
  always @(posedge clk_i) begin
    #1;
    irdata_i = mem_next;
  end

  // scoreboard: requests and deliveries must each follow program order from the last reset/redirect
  always @(negedge clk_i) begin
    if (reset_i) begin
      chk("rst_ird", {31'b0, ird_o}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rst_halted", {31'b0, halted_o}, 32'd0);
      exp_f = RESET_PC;
      exp_d = RESET_PC;
      hp = 1'b0;
    end else begin
      chk("addr_align", {30'b0, iaddr_o[1:0]}, 32'd0);
      if (inst_valid_o && inst_ready_i) begin
        chk("deliv_pc", inst_pc_o, exp_d);
        chk("deliv_inst", inst_o, rom(exp_d));
        exp_d = exp_d + 32'd4;
      end
      if (redirect_i) begin
        chk("redir_ird", {31'b0, ird_o}, 32'd0);
        exp_f = {redirect_pc_i[31:2], 2'b00};
        exp_d = exp_f;
        hp = 1'b0;
      end else begin
        if (hp) chk("halt_no_req", {31'b0, ird_o}, 32'd0);
        if (ird_o && accept_i) begin
          chk("req_addr", iaddr_o, exp_f);
`ifdef IFETCH_HALT_DETECT_EN
          if (iaddr_o == 32'hD4) hp = 1'b1;
`endif
          exp_f = exp_f + 32'd4;
        end
      end
`ifdef IFETCH_HALT_DETECT_EN
      if (halted_o) chk("halted_drained", {31'b0, hp && !inst_valid_o}, 32'd1);
`else
      chk("halted_tied", {31'b0, halted_o}, 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    chk("rst_ird_lit", {31'b0, ird_o}, 32'd0);
    // basic streaming: requests 0,4,8 back to back, one delivery per cycle
    step(); reset_i = 1'b0; look();
    chk("c0_addr", iaddr_o, 32'h0);
    chk("c0_ird", {31'b0, ird_o}, 32'd1);
    step(); look();
    chk("c1_addr", iaddr_o, 32'h4);
    chk("c1_valid", {31'b0, inst_valid_o}, 32'd0);
    step(); look();
    chk("c2_addr", iaddr_o, 32'h8);
    chk("c2_pc", inst_pc_o, 32'h0);
    chk("c2_inst", inst_o, 32'h1000_0000);
    step(); look();
    chk("c3_pc", inst_pc_o, 32'h4);
    chk("c3_inst", inst_o, 32'h1000_0004);
    step(); look();
    chk("c4_pc", inst_pc_o, 32'h8);
    // decode stall: buffer fills to FIFO_DEPTH and fetch stops
    step(); inst_ready_i = 1'b0;
    repeat (10) step();
    look();
    chk("stall_ird", {31'b0, ird_o}, 32'd0);
    chk("stall_valid", {31'b0, inst_valid_o}, 32'd1);
    step(); inst_ready_i = 1'b1; accept_i = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (inst_valid_o) n++;
      step();
    end
    chk("stall_count", n, FIFO_DEPTH);
    // memory back-pressure at 0x10
    redirect_i = 1'b1; redirect_pc_i = 32'h10;
    step(); redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("bp_addr", iaddr_o, 32'h10);
      chk("bp_ird", {31'b0, ird_o}, 32'd1);
      step();
    end
    accept_i = 1'b1; look();
    chk("bp_acc_addr", iaddr_o, 32'h10);
    step(); look();
    chk("bp_next_addr", iaddr_o, 32'h14);
    // redirect with a response in flight
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h87; look();
    chk("rd_ird", {31'b0, ird_o}, 32'd0);
    step(); redirect_i = 1'b0; look();
    chk("rd_empty", {31'b0, inst_valid_o}, 32'd0);
    chk("rd_addr", iaddr_o, 32'h84);
    chk("rd_req", {31'b0, ird_o}, 32'd1);
    step(); look();
    chk("rd_empty2", {31'b0, inst_valid_o}, 32'd0);
    step(); look();
    chk("rd_first_pc", inst_pc_o, 32'h84);
    // HALT word at 0xD4
    step(); redirect_i = 1'b1; redirect_pc_i = 32'hC8;
    step(); redirect_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      look();
      if (ird_o && iaddr_o == 32'hD8) seen_d8 = 1'b1;
      if (inst_valid_o && inst_pc_o == 32'hD4) d4_val = inst_o;
      if (halted_o) seen_halt = 1'b1;
      step();
    end
`ifdef IFETCH_HALT_DETECT_EN
    chk("halt_seen", {31'b0, seen_halt}, 32'd1);
    chk("halt_final", {31'b0, halted_o}, 32'd1);
    chk("halt_no_d8", {31'b0, seen_d8}, 32'd0);
    chk("halt_pc", iaddr_o, 32'hD8);
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step(); redirect_i = 1'b0; look();
    chk("resume_halted", {31'b0, halted_o}, 32'd0);
    chk("resume_addr", iaddr_o, 32'h0);
    chk("resume_ird", {31'b0, ird_o}, 32'd1);
`else
    chk("nohalt_d4", d4_val, 32'hFFFF_FFFF);
    chk("nohalt_d8", {31'b0, seen_d8}, 32'd1);
    chk("nohalt_halted", {31'b0, halted_o}, 32'd0);
`endif
    // reset pulse while a response is pending
    step(); step(); step();
    reset_i = 1'b1; look();
    chk("rp_ird", {31'b0, ird_o}, 32'd0);
    step(); reset_i = 1'b0; look();
    chk("rp_addr", iaddr_o, RESET_PC);
    chk("rp_ird1", {31'b0, ird_o}, 32'd1);
    chk("rp_empty", {31'b0, inst_valid_o}, 32'd0);
    step(); look();
    chk("rp_empty2", {31'b0, inst_valid_o}, 32'd0);
    step(); look();
    chk("rp_first_pc", inst_pc_o, RESET_PC);
    chk("rp_first_inst", inst_o, 32'h1000_0000);
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
